// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: issues one FPU operation at a time, times the unit latency, returns the result on valid/ready.
module fpu_op_sequencer #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 16,
  parameter int LAT_SQRT = 16,
  parameter int LAT_MAC  = 6,
  parameter int LAT_CONV = 2,
  parameter int LAT_MISC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic        req_sub,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_c,
  output logic [3:0]  ena,
  output logic        start,
  output logic        sub,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] op_c,
  input  logic [31:0] out_muxed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [3:0]  ena_q;
  logic        start_q;
  logic        sub_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] c_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;
  logic [4:0]  lat_d;
  logic        legal_d;
  always_comb begin
    legal_d = (req_op >= 4'd1) && (req_op <= 4'd9);
    lat_d = (req_op == 4'd1) ? 5'(LAT_ADD)  :
            (req_op == 4'd2) ? 5'(LAT_MUL)  :
            (req_op == 4'd3) ? 5'(LAT_DIV)  :
            (req_op == 4'd4) ? 5'(LAT_SQRT) :
            (req_op == 4'd5 || req_op == 4'd6) ? 5'(LAT_MISC) :
            (req_op == 4'd7 || req_op == 4'd8) ? 5'(LAT_CONV) :
            5'(LAT_MAC);
  end
  // Counter holds cycles left in BUSY including the current one; capture when it reads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ena_q       <= '0;
      start_q     <= 1'b0;
      sub_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          sub_q <= req_sub;
          a_q   <= req_a;
          b_q   <= req_b;
          c_q   <= req_c;
          if (legal_d) begin
            ena_q   <= req_op;
            cnt_q   <= lat_d;
            start_q <= 1'b1;
            state_q <= BUSY;
          end else begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b1;
            state_q     <= RESP;
          end
        end
        BUSY: begin
          start_q <= 1'b0;
          cnt_q   <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            resp_data_q <= out_muxed;
            resp_err_q  <= 1'b0;
            ena_q       <= '0;
            state_q     <= RESP;
          end
        end
        RESP: if (resp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign ena        = ena_q;
  assign start      = start_q;
  assign sub        = sub_q;
  assign op_a       = a_q;
  assign op_b       = b_q;
  assign op_c       = c_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: directed checks of handshake timing, latencies, illegal ops and reset abort.
module tb_fpu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_sub = 1'b0;
  logic        resp_ready = 1'b0;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [31:0] req_c = '0;
  logic        req_ready;
  logic [3:0]  ena;
  logic        start;
  logic        sub;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] op_c;
  logic [31:0] out_muxed;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        stub_sweep = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  int          acc_n = 0;
  int          acc_cyc = 0;
  int          rv_n = 0;
  int          rv_cyc = 0;
  int          st_n = 0;
  int          st_cyc = 0;
  int          en_n = 0;
  logic        rv_prev = 1'b0;
  logic [31:0] rv_data = '0;
  logic        rv_err = 1'b0;

  fpu_op_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_sub(req_sub), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .ena(ena), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .out_muxed(out_muxed), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] stub_val(input int k);
    return {16'hC0DE, k[15:0]};
  endfunction

  function automatic int lat_of(input int op);
    case (op)
      1: return 3;
      2: return 4;
      3: return 16;
      4: return 16;
      5, 6: return 1;
      7, 8: return 2;
      default: return 6;
    endcase
  endfunction

  assign out_muxed = stub_sweep ? stub_val(cyc) : ((ena == 4'd1) ? 32'h40400000 : 32'h0);

  // Event monitor: values read at the edge belong to the cycle numbered by cyc.
  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) begin
      acc_n   <= acc_n + 1;
      acc_cyc <= cyc;
    end
    if (resp_valid && !rv_prev) begin
      rv_n    <= rv_n + 1;
      rv_cyc  <= cyc;
      rv_data <= resp_data;
      rv_err  <= resp_err;
    end
    rv_prev <= resp_valid;
    if (start) begin
      st_n   <= st_n + 1;
      st_cyc <= cyc;
    end
    if (ena != 4'd0) en_n <= en_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_acc();
    int n0, k;
    n0 = acc_n;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (acc_n == n0 && k < 200);
    check("accepted", 32'(acc_n - n0), 32'd1);
  endtask

  task automatic issue(input logic [3:0] op, input logic s, input logic [31:0] a, b, c, input bit hold);
    req_op = op;
    req_sub = s;
    req_a = a;
    req_b = b;
    req_c = c;
    req_valid = 1'b1;
    wait_acc();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int r0, k;
    r0 = rv_n;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rv_n == r0 && k < 200);
    check("resp_seen", 32'(rv_n - r0), 32'd1);
  endtask

  initial begin
    int t, t1, s0, e0, r0;
    logic [31:0] exp;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_ena", 32'(ena), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);

    // add with a stub that only answers while ena selects the adder
    s0 = st_n;
    issue(4'd1, 1'b0, 32'h3F800000, 32'h40000000, 32'h0, 1'b0);
    t = acc_cyc;
    check("add_start", 32'(start), 32'd1);
    check("add_ena", 32'(ena), 32'd1);
    check("add_op_a", op_a, 32'h3F800000);
    check("add_op_b", op_b, 32'h40000000);
    check("add_req_ready_busy", 32'(req_ready), 32'd0);
    wait_resp();
    check("add_resp_lat", 32'(rv_cyc - t), 32'd4);
    check("add_start_cnt", 32'(st_n - s0), 32'd1);
    check("add_start_cyc", 32'(st_cyc - t), 32'd1);
    check("add_data", rv_data, 32'h40400000);
    check("add_err", 32'(rv_err), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("add_drop_valid", 32'(resp_valid), 32'd0);
    check("add_idle", 32'(req_ready), 32'd1);

    // div with response backpressure
    stub_sweep = 1'b1;
    issue(4'd3, 1'b0, 32'h11111111, 32'h22222222, 32'h0, 1'b0);
    t = acc_cyc;
    wait_resp();
    exp = stub_val(t + 16);
    check("div_resp_lat", 32'(rv_cyc - t), 32'd17);
    for (int i = 0; i < 5; i++) begin
      check("div_hold_data", resp_data, exp);
      check("div_hold_valid", 32'(resp_valid), 32'd1);
      check("div_hold_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("div_idle", 32'(req_ready), 32'd1);
    check("div_drop_valid", 32'(resp_valid), 32'd0);

    // illegal opcode goes straight to a response
    s0 = st_n;
    e0 = en_n;
    issue(4'd12, 1'b0, 32'h5, 32'h6, 32'h7, 1'b0);
    t = acc_cyc;
    check("ill_valid", 32'(resp_valid), 32'd1);
    check("ill_data", resp_data, 32'd0);
    check("ill_err", 32'(resp_err), 32'd1);
    check("ill_ena", 32'(ena), 32'd0);
    wait_resp();
    check("ill_resp_lat", 32'(rv_cyc - t), 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("ill_no_start", 32'(st_n - s0), 32'd0);
    check("ill_no_ena", 32'(en_n - e0), 32'd0);

    // back-to-back sign then mac with req_valid held
    resp_ready = 1'b1;
    issue(4'd5, 1'b0, 32'hA, 32'hB, 32'hC, 1'b1);
    t1 = acc_cyc;
    req_op = 4'd9;
    req_a = 32'h0A0A0A0A;
    req_b = 32'h0B0B0B0B;
    req_c = 32'h0C0C0C0C;
    wait_acc();
    req_valid = 1'b0;
    t = acc_cyc;
    check("b2b_spacing", 32'(t - t1), 32'd3);
    check("sign_resp_lat", 32'(rv_cyc - t1), 32'd2);
    check("sign_data", rv_data, stub_val(t1 + 1));
    check("mac_ena", 32'(ena), 32'd9);
    check("mac_op_c", op_c, 32'h0C0C0C0C);
    wait_resp();
    check("mac_resp_lat", 32'(rv_cyc - t), 32'd7);
    check("mac_data", rv_data, stub_val(t + 6));
    resp_ready = 1'b0;
    @(negedge clk);

    // reset in the 8th busy cycle of sqrt
    issue(4'd4, 1'b0, 32'h40800000, 32'h0, 32'h0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    r0 = rv_n;
    check("abort_ena", 32'(ena), 32'd0);
    check("abort_start", 32'(start), 32'd0);
    check("abort_valid", 32'(resp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_data", resp_data, 32'd0);
    repeat (25) @(negedge clk);
    check("abort_no_resp", 32'(rv_n - r0), 32'd0);

    // latency sweep over every legal opcode
    resp_ready = 1'b1;
    for (int op = 1; op <= 9; op++) begin
      issue(4'(op), op == 1, 32'(op * 16), 32'(op * 256), 32'(op * 4096), 1'b0);
      t = acc_cyc;
      if (op == 1) check("sweep_sub", 32'(sub), 32'd1);
      check($sformatf("sweep_ena_%0d", op), 32'(ena), 32'(op));
      wait_resp();
      check($sformatf("sweep_lat_%0d", op), 32'(rv_cyc - t), 32'(lat_of(op) + 1));
      check($sformatf("sweep_data_%0d", op), rv_data, stub_val(t + lat_of(op)));
      check($sformatf("sweep_err_%0d", op), 32'(rv_err), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
